// File: rtl/screen_ctrl.sv
// screen_ctrl: screen sequencer for the sudoku VGA path.
// Tracks the live screen, decodes start/return button clicks, defers screen
// changes to the next frame start and registers the selected pixel colour.
//
// state (screen) | meaning
// ---------------+--------------------------------------------
// MENU           | title screen, start button live
// PLAY           | game running, game_over pulse accepted
// OVER           | game-over screen, return button live
module screen_ctrl #(
  parameter logic [9:0] START_X0 = 10'd256,
  parameter logic [9:0] START_X1 = 10'd383,
  parameter logic [9:0] START_Y0 = 10'd300,
  parameter logic [9:0] START_Y1 = 10'd347,
  parameter logic [9:0] RET_X0   = 10'd256,
  parameter logic [9:0] RET_X1   = 10'd383,
  parameter logic [9:0] RET_Y0   = 10'd360,
  parameter logic [9:0] RET_Y1   = 10'd407
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  MOUSE_X,
  input  logic [9:0]  MOUSE_Y,
  input  logic        MOUSE_LEFT,
  input  logic        game_over,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic [11:0] pixel_menu_in,
  input  logic [11:0] pixel_play_in,
  input  logic [11:0] pixel_over_in,
  output logic [1:0]  screen,
  output logic        mouse_on_start_button,
  output logic        mouse_on_return_button,
  output logic        game_reset,
  output logic [11:0] vga_rgb
);

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } screen_t;

  screen_t screen_q, screen_d;
  screen_t pend_screen_q, pend_screen_d;
  screen_t req_screen;
  logic    pend_valid_q, pend_valid_d;
  logic    armed_q, armed_d;
  logic    left_prev_q, fs_cond_prev_q;
  logic    game_reset_d;
  logic    in_start, in_ret, hover, rise, fall, click;
  logic    fs_cond, fs, commit, req_valid;

  assign in_start = (MOUSE_X >= START_X0) && (MOUSE_X <= START_X1) &&
                    (MOUSE_Y >= START_Y0) && (MOUSE_Y <= START_Y1);
  assign in_ret   = (MOUSE_X >= RET_X0) && (MOUSE_X <= RET_X1) &&
                    (MOUSE_Y >= RET_Y0) && (MOUSE_Y <= RET_Y1);
  // Only the button belonging to the live screen counts as hovered.
  assign hover    = ((screen_q == MENU) && in_start) || ((screen_q == OVER) && in_ret);

  assign rise     = MOUSE_LEFT && !left_prev_q;
  assign fall     = !MOUSE_LEFT && left_prev_q;
  assign click    = armed_q && fall && hover;

  // Counters dwell on (0,0) for several clk cycles; only the first one is a frame start.
  assign fs_cond  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign fs       = fs_cond && !fs_cond_prev_q;
  assign commit   = fs && pend_valid_q;

  assign screen   = screen_q;

  // Next-state: request decode, pending-request latch, click arming and commit.
  always_comb begin
    screen_d      = screen_q;
    pend_valid_d  = pend_valid_q;
    pend_screen_d = pend_screen_q;
    armed_d       = armed_q;
    game_reset_d  = 1'b0;
    req_valid     = 1'b0;
    req_screen    = MENU;

    case (screen_q)
      MENU: begin
        req_valid  = click;
        req_screen = PLAY;
      end
      PLAY: begin
        req_valid  = game_over;
        req_screen = OVER;
      end
      OVER: begin
        req_valid  = click;
        req_screen = MENU;
      end
      default: begin
        req_valid  = 1'b0;
        req_screen = MENU;
      end
    endcase

    if (commit) begin
      // A request arriving on the commit cycle is dropped: pend_valid is still set.
      screen_d     = pend_screen_q;
      pend_valid_d = 1'b0;
      armed_d      = 1'b0;
      game_reset_d = (pend_screen_q == PLAY);
    end else begin
      if (armed_q) begin
        if (!hover || fall) armed_d = 1'b0;
      end else if (rise && hover) begin
        armed_d = 1'b1;
      end
      if (!pend_valid_q && req_valid) begin
        pend_valid_d  = 1'b1;
        pend_screen_d = req_screen;
      end
    end
  end

  // State register for the screen sequencer and click tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      screen_q       <= MENU;
      pend_valid_q   <= 1'b0;
      pend_screen_q  <= MENU;
      armed_q        <= 1'b0;
      left_prev_q    <= 1'b0;
      fs_cond_prev_q <= 1'b0;
      game_reset     <= 1'b0;
    end else begin
      screen_q       <= screen_d;
      pend_valid_q   <= pend_valid_d;
      pend_screen_q  <= pend_screen_d;
      armed_q        <= armed_d;
      left_prev_q    <= MOUSE_LEFT;
      fs_cond_prev_q <= fs_cond;
      game_reset     <= game_reset_d;
    end
  end

  // Registered hover flags for the pixel generators, gated by the live screen.
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_on_start_button  <= 1'b0;
      mouse_on_return_button <= 1'b0;
    end else begin
      mouse_on_start_button  <= (screen_q == MENU) && in_start;
      mouse_on_return_button <= (screen_q == OVER) && in_ret;
    end
  end

  // Output pixel: black in blanking, otherwise the live screen's generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb <= 12'h000;
    end else if (!valid) begin
      vga_rgb <= 12'h000;
    end else begin
      case (screen_q)
        MENU:    vga_rgb <= pixel_menu_in;
        PLAY:    vga_rgb <= pixel_play_in;
        OVER:    vga_rgb <= pixel_over_in;
        default: vga_rgb <= 12'h000;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_ctrl.sv
// tb_screen_ctrl: directed bench for screen_ctrl with a small VGA timing
// generator and a commit scoreboard checked by an independent monitor.
module tb_screen_ctrl;
  localparam int H = 20;
  localparam int V = 10;
  localparam int F = 2 * H * V;  // clk cycles per frame (pixel enable = clk/2)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  mouse_x = 10'd0;
  logic [9:0]  mouse_y = 10'd0;
  logic        mouse_left = 1'b0;
  logic        game_over = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic        valid = 1'b1;
  logic [11:0] pixel_menu = 12'hA11;
  logic [11:0] pixel_play = 12'h2B2;
  logic [11:0] pixel_over = 12'h33C;
  logic [1:0]  screen;
  logic        hov_start, hov_ret, game_reset;
  logic [11:0] vga_rgb;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int last_scr = 0;

  typedef struct {
    int scr;
    int frame;  // frame index of the committing fs, -1 for a reset-forced change
  } exp_t;
  exp_t q[$];

  screen_ctrl dut (
    .clk(clk), .rst(rst),
    .MOUSE_X(mouse_x), .MOUSE_Y(mouse_y), .MOUSE_LEFT(mouse_left),
    .game_over(game_over), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .pixel_menu_in(pixel_menu), .pixel_play_in(pixel_play), .pixel_over_in(pixel_over),
    .screen(screen), .mouse_on_start_button(hov_start),
    .mouse_on_return_button(hov_ret), .game_reset(game_reset), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  // VGA timing: counters advance every second clk, active area 16x8.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      h_cnt = 10'((cyc / 2) % H);
      v_cnt = 10'((cyc / 2 / H) % V);
      valid = (h_cnt < 10'd16) && (v_cnt < 10'd8);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_exp(input int s, input int f);
    exp_t e;
    e.scr = s;
    e.frame = f;
    q.push_back(e);
  endtask

  task automatic wait_phase(input int p);
    int b = 0;
    while ((cyc % F) != p && b < F + 4) begin
      step(1);
      b++;
    end
  endtask

  task automatic wait_valid(input logic v);
    int b = 0;
    while (valid != v && b < F) begin
      step(1);
      b++;
    end
  endtask

  task automatic wait_commits();
    int b = 0;
    while (q.size() > 0 && b < 3 * F) begin
      step(1);
      b++;
    end
    check("commit_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic click(input int x, input int y, output int cr);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
    mouse_left = 1'b1;
    step(5);
    mouse_left = 1'b0;
    cr = cyc;
    step(1);
  endtask

  // Monitor: every screen change must match the next scoreboard entry,
  // land on the expected frame start, and pulse game_reset only into PLAY.
  always @(negedge clk) begin
    exp_t it;
    bit exp_gr;
    if (mon_en) begin
      exp_gr = 1'b0;
      if (int'(screen) != last_scr) begin
        if (q.size() == 0) begin
          check("unexpected_commit", int'(screen), last_scr);
        end else begin
          it = q.pop_front();
          check("commit_screen", int'(screen), it.scr);
          if (it.frame >= 0) check("commit_frame", (cyc - 1) / F, it.frame);
          exp_gr = (it.frame >= 0) && (screen == 2'd1);
        end
        last_scr = int'(screen);
      end
      if (exp_gr || game_reset) check("game_reset", int'(game_reset), int'(exp_gr));
    end
  end

  typedef struct {
    int x;
    int y;
    int hov;
  } hov_vec_t;

  initial begin
    int cr;
    hov_vec_t hv[6];
    hv[0] = '{256, 300, 1};
    hv[1] = '{255, 300, 0};
    hv[2] = '{383, 347, 1};
    hv[3] = '{384, 347, 0};
    hv[4] = '{300, 299, 0};
    hv[5] = '{300, 348, 0};

    // Reset with the cursor parked on the start button.
    rst = 1'b1;
    mouse_x = 10'd300;
    mouse_y = 10'd320;
    step(4);
    check("rst_screen", int'(screen), 0);
    check("rst_rgb", int'(vga_rgb), 0);
    check("rst_game_reset", int'(game_reset), 0);
    check("rst_hover_start", int'(hov_start), 0);
    check("rst_hover_ret", int'(hov_ret), 0);
    mouse_x = 10'd0;
    mouse_y = 10'd0;
    last_scr = 0;
    mon_en = 1'b1;
    rst = 1'b0;

    // Idle two frames in MENU.
    step(2 * F);
    check("idle_screen", int'(screen), 0);
    wait_valid(1'b0);
    step(1);
    check("blank_rgb", int'(vga_rgb), 0);
    wait_valid(1'b1);
    step(1);
    check("menu_rgb", int'(vga_rgb), 12'hA11);

    // Start-button bounds (inclusive edges) and return flag gated off in MENU.
    foreach (hv[i]) begin
      mouse_x = 10'(hv[i].x);
      mouse_y = 10'(hv[i].y);
      step(1);
      check("hover_start_bound", int'(hov_start), hv[i].hov);
    end
    mouse_x = 10'd300;
    mouse_y = 10'd380;
    step(1);
    check("hover_ret_in_menu", int'(hov_ret), 0);

    // Press on button, drag off and back on, release: leaving disarms.
    mouse_x = 10'd300; mouse_y = 10'd320; mouse_left = 1'b1; step(3);
    mouse_x = 10'd100; mouse_y = 10'd100; step(3);
    mouse_x = 10'd300; mouse_y = 10'd320; step(3);
    mouse_left = 1'b0; step(3);
    // Press off button, drag on, release: never arms.
    mouse_x = 10'd100; mouse_y = 10'd100; mouse_left = 1'b1; step(3);
    mouse_x = 10'd300; mouse_y = 10'd320; step(3);
    mouse_left = 1'b0; step(3);
    step(2 * F);
    check("cancel_screen", int'(screen), 0);

    // Start click commits PLAY at the next frame start.
    wait_phase(20);
    click(300, 320, cr);
    push_exp(1, cr / F + 1);
    wait_commits();
    check("play_screen", int'(screen), 1);
    mouse_x = 10'd300; mouse_y = 10'd320;
    step(1);
    check("hover_start_in_play", int'(hov_start), 0);
    wait_valid(1'b1);
    step(1);
    check("play_rgb", int'(vga_rgb), 12'h2B2);

    // Two game_over pulses 10 cycles apart: one commit to OVER.
    wait_phase(20);
    game_over = 1'b1;
    cr = cyc;
    step(1);
    game_over = 1'b0;
    push_exp(2, cr / F + 1);
    step(9);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    wait_commits();
    step(F);
    check("over_screen", int'(screen), 2);

    // OVER hover gating and pixel mux.
    mouse_x = 10'd300; mouse_y = 10'd380;
    step(1);
    check("hover_ret_in_over", int'(hov_ret), 1);
    check("hover_start_at_ret", int'(hov_start), 0);
    mouse_x = 10'd300; mouse_y = 10'd320;
    step(1);
    check("hover_start_in_over", int'(hov_start), 0);
    pixel_over = 12'h32E;
    wait_valid(1'b1);
    step(1);
    check("over_rgb", int'(vga_rgb), 12'h32E);
    wait_valid(1'b0);
    step(1);
    check("over_blank_rgb", int'(vga_rgb), 0);

    // Return click commits MENU.
    wait_phase(20);
    click(300, 380, cr);
    push_exp(0, cr / F + 1);
    wait_commits();

    // Release on the frame-start cycle: latched now, committed one frame later.
    mouse_x = 10'd300; mouse_y = 10'd320; mouse_left = 1'b1;
    wait_phase(F - 1);
    step(1);
    mouse_left = 1'b0;
    cr = cyc;
    step(1);
    push_exp(1, cr / F + 1);
    // game_over on the very cycle PLAY commits is dropped.
    wait_phase(F - 1);
    step(1);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    wait_commits();
    step(2 * F);
    check("go_at_commit_screen", int'(screen), 1);

    // Reset with OVER pending: back to MENU, nothing commits afterwards.
    wait_phase(20);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(3);
    rst = 1'b1;
    push_exp(0, -1);
    step(1);
    rst = 1'b0;
    check("rst_mid_screen", int'(screen), 0);
    step(2 * F);
    check("rst_mid_after", int'(screen), 0);

    // Reset in OVER with a return request pending.
    wait_phase(20);
    click(300, 320, cr);
    push_exp(1, cr / F + 1);
    wait_commits();
    wait_phase(20);
    game_over = 1'b1;
    cr = cyc;
    step(1);
    game_over = 1'b0;
    push_exp(2, cr / F + 1);
    wait_commits();
    wait_phase(20);
    click(300, 380, cr);
    rst = 1'b1;
    push_exp(0, -1);
    step(1);
    rst = 1'b0;
    check("rst_over_screen", int'(screen), 0);
    step(2 * F);
    check("rst_over_after", int'(screen), 0);

    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
